// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB requester with wait states and ACCESS timeout
//   CLK, RESET              clock and synchronous active-high reset
//   req_valid/ready/write/addr/wdata   command in (one transfer outstanding at a time)
//   rsp_valid/ready/rdata/err/timeout  response out, held until rsp_ready
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA   APB request side (all registered)
//   PRDATA/PREADY/PSLVERR              APB completion side from the slave
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic            timeout_hit;
  // cnt_q counts earlier stalled ACCESS cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  assign timeout_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == TO_W'(TIMEOUT - 1));
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q   <= SETUP;
          req_ready <= 1'b0;
          PSEL      <= 1'b1;
          PADDR     <= req_addr;
          PWRITE    <= req_write;
          PWDATA    <= req_wdata;
        end
        SETUP: begin
          state_q <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (!PREADY) cnt_q <= cnt_q + TO_W'(1);
          if (PREADY || timeout_hit) begin
            state_q     <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
            rsp_err     <= PREADY ? PSLVERR : 1'b1;
            rsp_timeout <= !PREADY;
          end
        end
        RESP: if (rsp_ready) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
